// File: rtl/mc_datapath_param.sv
// Parametrised multi-cycle MIPS-style datapath: PC/IR/MDR/ALUout/EPC, register file and ALU.
// MIO_ready low freezes all state; a TrapEn'd signed overflow vectors to TRAP_VEC and saves the PC in EPC.
module mc_datapath_param #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h80)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MIO_ready,
  input  logic            IorD,
  input  logic            IRWrite,
  input  logic [1:0]      RegDst,
  input  logic            RegWrite,
  input  logic [1:0]      MemtoReg,
  input  logic [1:0]      ALUSrcA,
  input  logic [2:0]      ALUSrcB,
  input  logic [1:0]      PCSource,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic            Branch,
  input  logic [2:0]      ALU_operation,
  input  logic            TrapEn,
  input  logic [XLEN-1:0] data2CPU,
  output logic [XLEN-1:0] PC_Current,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] M_addr,
  output logic            zero,
  output logic            overflow,
  output logic [XLEN-1:0] EPC,
  output logic            trap_taken
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]             pc_q, pc_d, mdr_q, alu_q, epc_q;
  logic [31:0]                 ir_q;
  logic                        tt_q;
  logic [NREGS-1:0][XLEN-1:0]  rf_q;

  logic                        adv, trap, pc_we, rf_we;
  logic [AW-1:0]               ra, rb, rd, wa;
  logic [15:0]                 imm;
  logic [XLEN-1:0]             rs_v, rt_v, a, b, res, wd, pc_src, sext, zext, lui;

  assign adv  = MIO_ready & ~reset;
  assign ra   = ir_q[21 +: AW];
  assign rb   = ir_q[16 +: AW];
  assign rd   = ir_q[11 +: AW];
  // Entry 0 is cleared on reset and never written, so it always reads 0.
  assign rs_v = rf_q[ra];
  assign rt_v = rf_q[rb];

  assign imm  = ir_q[15:0];
  assign sext = XLEN'($signed(imm));
  assign zext = XLEN'(imm);
  assign lui  = XLEN'($signed({imm, 16'h0000}));

  always_comb begin
    a = '0;
    case (ALUSrcA)
      2'd0:    a = pc_q;
      2'd1:    a = rs_v;
      2'd2:    a = rt_v;
      default: a = '0;
    endcase
    b = '0;
    case (ALUSrcB)
      3'd0:    b = rt_v;
      3'd1:    b = XLEN'(4);
      3'd2:    b = sext;
      3'd3:    b = zext;
      3'd4:    b = sext << 2;
      default: b = '0;
    endcase
  end

  always_comb begin
    res      = '0;
    overflow = 1'b0;
    case (ALU_operation)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b011: res = a ^ b;
      3'b100: res = ~(a | b);
      3'b101: res = a >> b[4:0];
      3'b111: res = XLEN'($signed(a) < $signed(b));
      3'b010: begin
        res      = a + b;
        overflow = (a[XLEN-1] == b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
      end
      3'b110: begin
        res      = a - b;
        overflow = (a[XLEN-1] != b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
      end
      default: res = '0;
    endcase
  end

  assign zero  = (res == '0);
  assign trap  = TrapEn & overflow & adv;
  assign pc_we = PCWrite | (PCWriteCond & (zero == Branch));

  always_comb begin
    pc_src = res;
    case (PCSource)
      2'd0:    pc_src = res;
      2'd1:    pc_src = alu_q;
      2'd2:    pc_src = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
      default: pc_src = rs_v;
    endcase
    // Trap has priority over any PC load the controller requested.
    pc_d = trap ? TRAP_VEC : (pc_we ? pc_src : pc_q);

    wa = rb;
    case (RegDst)
      2'd1:    wa = rd;
      2'd2:    wa = AW'(NREGS - 1);
      default: wa = rb;
    endcase
    wd = alu_q;
    case (MemtoReg)
      2'd0:    wd = alu_q;
      2'd1:    wd = mdr_q;
      2'd2:    wd = lui;
      default: wd = pc_q;
    endcase
  end

  assign rf_we = RegWrite & ~trap & (wa != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
      alu_q <= '0;
      epc_q <= '0;
      tt_q  <= 1'b0;
      rf_q  <= '0;
    end else if (adv) begin
      pc_q  <= pc_d;
      mdr_q <= data2CPU;
      alu_q <= res;
      tt_q  <= trap;
      if (IRWrite) ir_q <= data2CPU[31:0];
      if (trap)    epc_q <= pc_q;
      if (rf_we)   rf_q[wa] <= wd;
    end
  end

  assign PC_Current = pc_q;
  assign Inst       = ir_q;
  assign EPC        = epc_q;
  assign trap_taken = tt_q;
  assign data_out   = rt_v;
  assign M_addr     = IorD ? alu_q : pc_q;
endmodule

// File: tb/tb_mc_datapath_param.sv
// Bench for mc_datapath_param: directed sequences and an ALU vector table on a 32-bit build,
// parameter checks on a 64-bit/8-register build, then randomized cycles against a behavioural model.
module tb_mc_datapath_param;
  logic        clk, reset, mio, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, TrapEn;
  logic [1:0]  RegDst, MemtoReg, ALUSrcA, PCSource;
  logic [2:0]  ALUSrcB, op;
  logic [63:0] din;

  logic [31:0] pc32, inst32, do32, ma32, epc32;
  logic        z32, o32, tt32;
  logic [63:0] pc64, do64, ma64, epc64;
  logic [31:0] inst64;
  logic        z64, o64, tt64;

  int nvec = 0, nerr = 0;

  mc_datapath_param #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100), .TRAP_VEC(32'h80)) u32 (
    .clk(clk), .reset(reset), .MIO_ready(mio), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(op), .TrapEn(TrapEn), .data2CPU(din[31:0]), .PC_Current(pc32), .Inst(inst32),
    .data_out(do32), .M_addr(ma32), .zero(z32), .overflow(o32), .EPC(epc32), .trap_taken(tt32));

  mc_datapath_param #(.XLEN(64), .NREGS(8), .RESET_PC(64'h40), .TRAP_VEC(64'h80)) u64 (
    .clk(clk), .reset(reset), .MIO_ready(mio), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(op), .TrapEn(TrapEn), .data2CPU(din), .PC_Current(pc64), .Inst(inst64),
    .data_out(do64), .M_addr(ma64), .zero(z64), .overflow(o64), .EPC(epc64), .trap_taken(tt64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z, o;
  } alu_vec_t;
  alu_vec_t tbl [13];

  // behavioural model state of the 32-bit build
  logic [31:0] m_pc, m_ir, m_mdr, m_alu, m_epc;
  logic        m_tt;
  logic [31:0] m_rf [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    mio = 1'b1; IorD = 0; IRWrite = 0; RegDst = 0; RegWrite = 0; MemtoReg = 0;
    ALUSrcA = 0; ALUSrcB = 0; PCSource = 0; PCWrite = 0; PCWriteCond = 0; Branch = 0;
    op = 3'b000; TrapEn = 0; din = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [31:0] i);
    idle(); IRWrite = 1; din = {32'h0, i}; cyc(); idle();
  endtask

  task automatic set_mdr(input logic [63:0] v);
    idle(); din = v; cyc(); idle();
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] v);
    load_ir({6'h0, 5'd0, idx, 16'h0});
    set_mdr(v);
    RegDst = 0; MemtoReg = 1; RegWrite = 1; cyc(); idle();
  endtask

  task automatic fetch_ctl();
    idle(); PCWrite = 1; ALUSrcA = 0; ALUSrcB = 1; op = 3'b010; PCSource = 0; IRWrite = 1;
    din = 64'h2008_0005;
  endtask

  task automatic reset_pulse();
    idle(); reset = 1; @(negedge clk); reset = 0;
  endtask

  task automatic rand_step();
    logic [31:0] a, b, r, rs, rt, wd, psrc, imm_s;
    logic        z, ovf, trap;
    logic [4:0]  wi;
    longint      exact;
    mio = ($urandom_range(0, 3) != 0);
    IorD = 1'($urandom_range(0, 1)); IRWrite = 1'($urandom_range(0, 1));
    RegDst = 2'($urandom_range(0, 3)); RegWrite = 1'($urandom_range(0, 1));
    MemtoReg = 2'($urandom_range(0, 3)); ALUSrcA = 2'($urandom_range(0, 3));
    ALUSrcB = 3'($urandom_range(0, 7)); PCSource = 2'($urandom_range(0, 3));
    PCWrite = ($urandom_range(0, 3) == 0); PCWriteCond = 1'($urandom_range(0, 1));
    Branch = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
    TrapEn = ($urandom_range(0, 2) == 0); din = {$urandom, $urandom};
    #1;
    rs = m_rf[m_ir[25:21]];
    rt = m_rf[m_ir[20:16]];
    imm_s = {{16{m_ir[15]}}, m_ir[15:0]};
    case (ALUSrcA) 0: a = m_pc; 1: a = rs; 2: a = rt; default: a = 0; endcase
    case (ALUSrcB)
      0: b = rt; 1: b = 4; 2: b = imm_s; 3: b = {16'h0, m_ir[15:0]}; 4: b = imm_s * 4;
      default: b = 0;
    endcase
    ovf = 0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b010: begin
        r = a + b;
        exact = longint'($signed(a)) + longint'($signed(b));
        ovf = (exact != longint'($signed(r)));
      end
      3'b110: begin
        r = a - b;
        exact = longint'($signed(a)) - longint'($signed(b));
        ovf = (exact != longint'($signed(r)));
      end
      3'b111: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      default: r = 32'(longint'(a) / (longint'(1) << b[4:0]));
    endcase
    z = (r == 0);
    chk("rnd zero", 64'(z32), 64'(z));
    chk("rnd overflow", 64'(o32), 64'(ovf));
    chk("rnd M_addr", 64'(ma32), 64'(IorD ? m_alu : m_pc));
    chk("rnd data_out", 64'(do32), 64'(rt));
    trap = TrapEn && ovf && mio;
    case (RegDst) 1: wi = m_ir[15:11]; 2: wi = 5'd31; default: wi = m_ir[20:16]; endcase
    case (MemtoReg) 0: wd = m_alu; 1: wd = m_mdr; 2: wd = {m_ir[15:0], 16'h0}; default: wd = m_pc; endcase
    case (PCSource)
      0: psrc = r; 1: psrc = m_alu; 2: psrc = {m_pc[31:28], m_ir[25:0], 2'b00}; default: psrc = rs;
    endcase
    @(posedge clk);
    if (mio) begin
      if (RegWrite && !trap && wi != 0) m_rf[wi] = wd;
      if (trap) begin
        m_epc = m_pc;
        m_pc  = 32'h80;
      end else if (PCWrite || (PCWriteCond && (z == Branch))) m_pc = psrc;
      m_mdr = din[31:0];
      m_alu = r;
      if (IRWrite) m_ir = din[31:0];
      m_tt = trap;
    end
    #1;
    chk("rnd PC", 64'(pc32), 64'(m_pc));
    chk("rnd Inst", 64'(inst32), 64'(m_ir));
    chk("rnd EPC", 64'(epc32), 64'(m_epc));
    chk("rnd trap_taken", 64'(tt32), 64'(m_tt));
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0005, 32'h0000_0007, 3'b010, 32'h0000_000C, 1'b0, 1'b0};
    tbl[1]  = '{32'h0000_0007, 32'h0000_0007, 3'b110, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3]  = '{32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[4]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0};
    tbl[5]  = '{32'h0F0F_0000, 32'h0000_00F0, 3'b001, 32'h0F0F_00F0, 1'b0, 1'b0};
    tbl[6]  = '{32'hFFFF_0000, 32'hFF00_FF00, 3'b011, 32'h00FF_FF00, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 3'b100, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[8]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_0005, 32'hFFFF_FFFE, 3'b111, 32'h0000_0000, 1'b1, 1'b0};
    tbl[10] = '{32'h8000_0000, 32'h0000_0038, 3'b101, 32'h0000_0080, 1'b0, 1'b0};
    tbl[11] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0};
    tbl[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b000, 32'h7FFF_FFFF, 1'b0, 1'b0};

    idle(); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;

    // fetch, then asynchronous reset mid-cycle
    fetch_ctl(); cyc();
    chk("fetch PC", 64'(pc32), 64'h104);
    chk("fetch Inst", 64'(inst32), 64'h2008_0005);
    idle(); #2 reset = 1; #1;
    chk("async reset PC", 64'(pc32), 64'h100);
    chk("async reset Inst", 64'(inst32), 64'h0);
    chk("async reset EPC", 64'(epc32), 64'h0);
    chk("async reset trap_taken", 64'(tt32), 64'h0);
    chk("async reset PC64", pc64, 64'h40);
    chk("async reset Inst64", 64'(inst64), 64'h0);
    chk("async reset EPC64", epc64, 64'h0);
    chk("async reset trap_taken64", 64'(tt64), 64'h0);
    @(negedge clk); reset = 0;

    // stall for three cycles, then release
    fetch_ctl(); mio = 0; IorD = 1;
    repeat (3) cyc();
    chk("stall PC", 64'(pc32), 64'h100);
    chk("stall Inst", 64'(inst32), 64'h0);
    chk("stall ALUout", 64'(ma32), 64'h0);
    mio = 1; cyc();
    chk("post-stall PC", 64'(pc32), 64'h104);
    chk("post-stall Inst", 64'(inst32), 64'h2008_0005);
    chk("post-stall ALUout", 64'(ma32), 64'h104);

    // ALU vector table: rs=r1=a, rt=r2=b
    for (int i = 0; i < 13; i++) begin
      write_reg(5'd1, {32'h0, tbl[i].a});
      write_reg(5'd2, {32'h0, tbl[i].b});
      load_ir({6'h0, 5'd1, 5'd2, 16'h0});
      ALUSrcA = 1; ALUSrcB = 0; op = tbl[i].op; #1;
      chk($sformatf("alu[%0d] zero", i), 64'(z32), 64'(tbl[i].z));
      chk($sformatf("alu[%0d] overflow", i), 64'(o32), 64'(tbl[i].o));
      chk($sformatf("alu[%0d] data_out", i), 64'(do32), 64'(tbl[i].b));
      cyc(); IorD = 1; #1;
      chk($sformatf("alu[%0d] ALUout", i), 64'(ma32), 64'(tbl[i].res));
    end

    // branch taken (rs==rt) and not taken (rs!=rt)
    write_reg(5'd1, 64'd7); write_reg(5'd2, 64'd7);
    load_ir({6'h04, 5'd1, 5'd2, 16'h0200});
    ALUSrcA = 3; ALUSrcB = 3; op = 3'b010; cyc(); idle();
    ALUSrcA = 1; ALUSrcB = 0; op = 3'b110; PCWriteCond = 1; Branch = 1; PCSource = 1; #1;
    chk("beq zero", 64'(z32), 64'h1);
    cyc();
    chk("beq taken PC", 64'(pc32), 64'h200);
    write_reg(5'd2, 64'd8);
    load_ir({6'h04, 5'd1, 5'd2, 16'h0300});
    ALUSrcA = 3; ALUSrcB = 3; op = 3'b010; cyc(); idle();
    ALUSrcA = 1; ALUSrcB = 0; op = 3'b110; PCWriteCond = 1; Branch = 1; PCSource = 1; #1;
    chk("beq not-taken zero", 64'(z32), 64'h0);
    cyc();
    chk("beq not-taken PC", 64'(pc32), 64'h200);

    // overflow trap with RegWrite and PCWrite also asserted
    write_reg(5'd1, 64'h7FFF_FFFF); write_reg(5'd2, 64'd1); write_reg(5'd3, 64'hABCD);
    load_ir({16'h0, 16'h0108});
    ALUSrcA = 3; ALUSrcB = 3; op = 3'b010; PCWrite = 1; PCSource = 0; cyc(); idle();
    chk("pre-trap PC", 64'(pc32), 64'h108);
    load_ir({6'h0, 5'd1, 5'd2, 5'd3, 11'h0});
    ALUSrcA = 1; ALUSrcB = 0; op = 3'b010; TrapEn = 1; RegWrite = 1; RegDst = 1;
    PCWrite = 1; PCSource = 0; #1;
    chk("trap overflow", 64'(o32), 64'h1);
    cyc();
    chk("trap PC", 64'(pc32), 64'h80);
    chk("trap EPC", 64'(epc32), 64'h108);
    chk("trap_taken set", 64'(tt32), 64'h1);
    load_ir({6'h0, 5'd0, 5'd3, 16'h0});
    chk("trap_taken one cycle", 64'(tt32), 64'h0);
    chk("trap rd unchanged", 64'(do32), 64'hABCD);

    // 64-bit, 8-register build
    reset_pulse();
    chk("x64 reset PC", pc64, 64'h40);
    set_mdr(64'hDEAD_BEEF_0123_4567);
    RegDst = 2; MemtoReg = 1; RegWrite = 1; cyc(); idle();
    load_ir({6'h0, 5'd0, 5'd7, 16'h0});
    chk("x64 link writes r7", do64, 64'hDEAD_BEEF_0123_4567);
    load_ir({6'h0, 5'd0, 5'd0, 5'd9, 11'h0});
    RegDst = 1; MemtoReg = 2; RegWrite = 1; cyc(); idle();
    load_ir({6'h0, 5'd0, 5'd1, 16'h0});
    chk("x64 rd=9 writes r1", do64, 64'h0000_0000_4800_0000);
    load_ir({6'h0, 5'd0, 5'd0, 5'd25, 11'h0});
    RegDst = 1; MemtoReg = 2; RegWrite = 1; cyc(); idle();
    load_ir({6'h0, 5'd0, 5'd1, 16'h0});
    chk("x64 lui sext to r1", do64, 64'hFFFF_FFFF_C800_0000);
    load_ir({16'h0, 16'hFFFC});
    ALUSrcA = 3; ALUSrcB = 2; op = 3'b010; #1;
    chk("x64 sext zero", 64'(z64), 64'h0);
    chk("x64 sext overflow", 64'(o64), 64'h0);
    cyc(); IorD = 1; #1;
    chk("x64 sext imm", ma64, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(); ALUSrcA = 3; ALUSrcB = 4; op = 3'b010; cyc(); IorD = 1; #1;
    chk("x64 sext imm<<2", ma64, 64'hFFFF_FFFF_FFFF_FFF0);
    load_ir({6'h0, 5'd0, 5'd8, 16'h0});
    set_mdr(64'h5555);
    RegDst = 0; MemtoReg = 1; RegWrite = 1; cyc(); idle();
    load_ir({6'h0, 5'd0, 5'd0, 16'h0});
    chk("x64 r0 write ignored", do64, 64'h0);

    // randomized cycles on the 32-bit build against the model
    reset_pulse();
    m_pc = 32'h100; m_ir = 0; m_mdr = 0; m_alu = 0; m_epc = 0; m_tt = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int n = 0; n < 400; n++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
